mem_stage_hs: RTL and testbench
===============================

Name: mem_stage_hs

Overview:
- Parametrised memory pipeline stage placed between EX and WB.
- Adds sub-word loads and stores (byte/half/word, plus double when XLEN=64) with byte enables and sign/zero extension.
- Drives a variable-latency data-memory request/response handshake and stalls upstream while a load is outstanding.
- Supports flush, including mid-load drain, a registered valid bit toward WB, and misalignment detection.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- WB_CTRL_W, 3, width of the write-back control field forwarded to WB.
- REG_ADDR_W, 5, destination register index width.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX/MEM holds a valid instruction; operands are held stable while in_ready=0.
- in_ready  out  1  stage consumes the instruction this cycle; low = stall upstream.
- ctrl_mem  in  WB_CTRL_W+2  bit[WB_CTRL_W+1]=mem_write, bit[WB_CTRL_W]=mem_read, low bits=WB control.
- funct3  in  3  access size/sign.
- rd_mem  in  REG_ADDR_W  destination register.
- pc4_mem  in  XLEN  PC+4.
- alu_result  in  XLEN  effective address / ALU value.
- write_data  in  XLEN  store source.
- flush  in  1  kill the instruction currently in MEM.
- dmem_req_valid  out  1  request valid.
- dmem_req_ready  in  1  memory accepts the request.
- dmem_we  out  1  1 = write.
- dmem_be  out  XLEN/8  byte enables.
- dmem_addr  out  XLEN  alu_result with low offset bits cleared.
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_rsp_valid  in  1  read data valid, one cycle per read.
- dmem_rsp_data  in  XLEN  read data, full aligned word.
- wb_valid  out  1  registered: WB holds a completed instruction.
- ctrl_wb  out  WB_CTRL_W  registered; forced 0 when wb_valid=0 or on misalign.
- rd_wb  out  REG_ADDR_W  registered.
- pc4_wb  out  XLEN  registered.
- mem_data  out  XLEN  registered, extended load result.
- alu_data  out  XLEN  registered alu_result.
- misaligned  out  1  registered, qualified by wb_valid.

Behaviour:
- Reset: asynchronous, active-low; clock is clk, reset is reset_n.
  - All registered outputs go to 0; FSM goes to IDLE.
  - Reset mid-load abandons the outstanding response; dmem shares reset_n.
- FSM states: IDLE, RSP (load outstanding), DRAIN (flushed load outstanding).
- Decode: mem op = mem_read | mem_write. off = alu_result[log2(XLEN/8)-1:0].
- Misaligned when:
  - half access with off[0]≠0;
  - word access with off[1:0]≠0;
  - double access with off≠0.
- IDLE, in_valid=0: in_ready=1, no request; WB regs load wb_valid=0, ctrl_wb=0.
- IDLE, non-mem instruction: in_ready=1; next edge wb_valid=1, alu_data=alu_result, mem_data=0. Latency 1.
- IDLE, flush=1: instruction consumed (in_ready=1), no request, next wb_valid=0. Flush has priority over everything.
- IDLE, misaligned mem op: no request, in_ready=1; next wb_valid=1, misaligned=1, ctrl_wb=0.
- IDLE, aligned mem op: dmem_req_valid=1, driven combinationally.
  - Store: in_ready=dmem_req_ready; on acceptance WB loads (posted write, latency 1 from accept).
  - Load: in_ready=0; on acceptance go to RSP.
  - While req_ready=0, in_ready=0 and request signals stay stable.
- RSP: in_ready=dmem_rsp_valid and no new request.
  - On rsp_valid, WB loads the extracted data and the FSM returns to IDLE.
  - flush=1 in RSP: in_ready=1, wb_valid=0 next; go to DRAIN, or straight to IDLE if rsp_valid is the same cycle (data discarded).
- DRAIN: in_ready=0, no request; on rsp_valid discard and return to IDLE. flush is ignored in DRAIN.
- wb_valid is high only in the cycle after a completion; ctrl_wb=0 otherwise, so WB never writes twice.
- Store encoding (funct3):
  - SB: wdata = byte replicated across lanes, be = 1<<off.
  - SH: halfword replicated, be = 3<<off.
  - SW: be = 4'hF<<off.
  - SD (XLEN=64 only): be = all ones.
- Load encoding (funct3): lane selected by off.
  - 000 LB, 001 LH, 010 LW: sign-extended.
  - 100 LBU, 101 LHU: zero-extended.
  - XLEN=64 adds 011 LD and 110 LWU.
- Illegal funct3 is treated as word size for both loads and stores.

Decomposition:
- Package mem_pkg:
  - funct3 size/sign constants;
  - FSM state enum (IDLE, RSP, DRAIN);
  - ctrl_mem bit-position constants.
- Sub-module mem_lane_align (combinational): store be/wdata generation, load extract/extend, misalign detect.
- The parent holds the FSM and WB registers.

Test Plan:
- Non-mem, alu_result=0x1234, rd=5, ctrl_wb=3'b101 -> next cycle wb_valid=1, alu_data=0x1234, rd_wb=5, ctrl_wb=3'b101; following idle cycle wb_valid=0, ctrl_wb=0.
- SB, addr=0x1003, write_data=0xAABBCCDD, req_ready held 0 for 2 cycles -> in_ready=0 for 2 cycles, be=4'b1000, wdata=0xDDDDDDDD, addr=0x1000; wb_valid one cycle after acceptance.
- LB addr=0x2002 with rsp 3 cycles later, rsp_data=0x0080FF00 -> mem_data=0xFFFFFF80; same with LBU -> 0x00000080; in_ready low until the rsp cycle.
- LH addr=0x3001 -> no dmem_req_valid, next wb_valid=1, misaligned=1, ctrl_wb=0.
- LW issued, flush one cycle after acceptance, rsp 2 cycles later -> wb_valid stays 0; following ADD accepted only after rsp; FSM RSP->DRAIN->IDLE.
- reset_n pulsed low during RSP -> all outputs 0 immediately (asynchronously), FSM IDLE, in_ready=1 after release.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the memory stage: funct3 access codes, access sizes,
// FSM states and ctrl_mem field offsets.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // mem_read / mem_write sit directly above the WB control field in ctrl_mem
  localparam int CTRL_RD_OFS = 0;
  localparam int CTRL_WR_OFS = 1;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
  typedef enum logic [1:0] {IDLE, RSP, DRAIN} state_e;

  // Anything unrecognised (including LD/SD on a 32-bit datapath) is a word access
  function automatic size_e decode_size(input logic [2:0] f3, input logic xlen64);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      F3_D:        return xlen64 ? SZ_D : SZ_W;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic decode_unsigned(input logic [2:0] f3, input logic xlen64);
    return (f3 == F3_BU) || (f3 == F3_HU) || (xlen64 && (f3 == F3_WU));
  endfunction

endpackage

// File: rtl/mem_stage_hs_if.sv
// Upstream, data-memory and write-back signals of the memory stage.
interface mem_stage_hs_if #(
  parameter int XLEN       = 32,
  parameter int WB_CTRL_W  = 3,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WB_CTRL_W+1:0]  ctrl_mem;
  logic [2:0]            funct3;
  logic [REG_ADDR_W-1:0] rd_mem;
  logic [XLEN-1:0]       pc4_mem;
  logic [XLEN-1:0]       alu_result;
  logic [XLEN-1:0]       write_data;
  logic                  flush;
  logic                  dmem_req_valid;
  logic                  dmem_req_ready;
  logic                  dmem_we;
  logic [XLEN/8-1:0]     dmem_be;
  logic [XLEN-1:0]       dmem_addr;
  logic [XLEN-1:0]       dmem_wdata;
  logic                  dmem_rsp_valid;
  logic [XLEN-1:0]       dmem_rsp_data;
  logic                  wb_valid;
  logic [WB_CTRL_W-1:0]  ctrl_wb;
  logic [REG_ADDR_W-1:0] rd_wb;
  logic [XLEN-1:0]       pc4_wb;
  logic [XLEN-1:0]       mem_data;
  logic [XLEN-1:0]       alu_data;
  logic                  misaligned;

  modport master (
    input  in_valid, ctrl_mem, funct3, rd_mem, pc4_mem, alu_result, write_data, flush,
           dmem_req_ready, dmem_rsp_valid, dmem_rsp_data,
    output in_ready, dmem_req_valid, dmem_we, dmem_be, dmem_addr, dmem_wdata,
           wb_valid, ctrl_wb, rd_wb, pc4_wb, mem_data, alu_data, misaligned
  );

  modport slave (
    output in_valid, ctrl_mem, funct3, rd_mem, pc4_mem, alu_result, write_data, flush,
           dmem_req_ready, dmem_rsp_valid, dmem_rsp_data,
    input  in_ready, dmem_req_valid, dmem_we, dmem_be, dmem_addr, dmem_wdata,
           wb_valid, ctrl_wb, rd_wb, pc4_wb, mem_data, alu_data, misaligned
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables and replicated data, load lane
// extraction with sign/zero extension, and alignment checking.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int BE_W  = XLEN / 8,
  localparam int OFF_W = $clog2(BE_W)
) (
  input  logic [2:0]       funct3_i,
  input  logic [OFF_W-1:0] off_i,
  input  logic [XLEN-1:0]  wdata_i,
  input  logic [XLEN-1:0]  rdata_i,
  output logic [BE_W-1:0]  be_o,
  output logic [XLEN-1:0]  wdata_o,
  output logic [XLEN-1:0]  rdata_o,
  output logic             misaligned_o
);

  size_e           size;
  logic            uns;
  logic [XLEN-1:0] lane;

  assign size = decode_size(funct3_i, XLEN == 64);
  assign uns  = decode_unsigned(funct3_i, XLEN == 64);
  assign lane = rdata_i >> {off_i, 3'b000};

  // Keep the low 'bits' of v and extend them back to the full width
  function automatic logic [XLEN-1:0] ext(input logic [XLEN-1:0] v, input int bits,
                                          input logic zero);
    logic [XLEN-1:0] sh;
    sh = v << (XLEN - bits);
    return zero ? (sh >> (XLEN - bits)) : XLEN'($signed(sh) >>> (XLEN - bits));
  endfunction

  always_comb begin
    be_o         = '0;
    wdata_o      = wdata_i;
    rdata_o      = '0;
    misaligned_o = 1'b0;
    case (size)
      SZ_B: begin
        be_o    = BE_W'(1) << off_i;
        wdata_o = {BE_W{wdata_i[7:0]}};
        rdata_o = ext(lane, 8, uns);
      end
      SZ_H: begin
        be_o         = BE_W'(3) << off_i;
        wdata_o      = {(XLEN/16){wdata_i[15:0]}};
        rdata_o      = ext(lane, 16, uns);
        misaligned_o = off_i[0];
      end
      SZ_W: begin
        be_o         = BE_W'(4'hF) << off_i;
        wdata_o      = {(XLEN/32){wdata_i[31:0]}};
        rdata_o      = ext(lane, 32, uns);
        misaligned_o = |off_i[1:0];
      end
      default: begin
        be_o         = '1;
        wdata_o      = wdata_i;
        rdata_o      = rdata_i;
        misaligned_o = |off_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_hs.sv
// Memory pipeline stage between EX and WB: drives a variable-latency dmem
// handshake, stalls upstream on outstanding loads and registers results to WB.
module mem_stage_hs
  import mem_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int WB_CTRL_W  = 3,
  parameter int REG_ADDR_W = 5
) (
  input logic          clk,
  input logic          reset_n,
  mem_stage_hs_if.master bus
);

  localparam int OFF_W = $clog2(XLEN / 8);

  logic                  mem_rd, mem_wr, is_mem, misal;
  logic [XLEN/8-1:0]     be;
  logic [XLEN-1:0]       wdata, rdata_ext;

  state_e                state_q, state_d;
  logic                  wb_valid_q, wb_valid_d;
  logic                  misal_q, misal_d;
  logic [WB_CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [XLEN-1:0]       mem_data_q, mem_data_d;
  logic [XLEN-1:0]       alu_q, pc4_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  wb_load, req_valid, in_ready;

  assign mem_rd = bus.ctrl_mem[WB_CTRL_W + CTRL_RD_OFS];
  assign mem_wr = bus.ctrl_mem[WB_CTRL_W + CTRL_WR_OFS];
  assign is_mem = mem_rd | mem_wr;

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .funct3_i    (bus.funct3),
    .off_i       (bus.alu_result[OFF_W-1:0]),
    .wdata_i     (bus.write_data),
    .rdata_i     (bus.dmem_rsp_data),
    .be_o        (be),
    .wdata_o     (wdata),
    .rdata_o     (rdata_ext),
    .misaligned_o(misal)
  );

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    req_valid  = 1'b0;
    wb_load    = 1'b0;
    wb_valid_d = 1'b0;
    ctrl_d     = '0;
    misal_d    = 1'b0;
    mem_data_d = '0;
    case (state_q)
      IDLE: begin
        if (bus.flush || !bus.in_valid) begin
          in_ready = 1'b1;
        end else if (!is_mem) begin
          in_ready   = 1'b1;
          wb_load    = 1'b1;
          wb_valid_d = 1'b1;
          ctrl_d     = bus.ctrl_mem[WB_CTRL_W-1:0];
        end else if (misal) begin
          in_ready   = 1'b1;
          wb_load    = 1'b1;
          wb_valid_d = 1'b1;
          misal_d    = 1'b1;
        end else begin
          req_valid = 1'b1;
          // Stores are posted: they retire on acceptance without waiting for memory
          if (mem_wr) begin
            in_ready = bus.dmem_req_ready;
            if (bus.dmem_req_ready) begin
              wb_load    = 1'b1;
              wb_valid_d = 1'b1;
              ctrl_d     = bus.ctrl_mem[WB_CTRL_W-1:0];
            end
          end else if (bus.dmem_req_ready) begin
            state_d = RSP;
          end
        end
      end
      RSP: begin
        if (bus.flush) begin
          in_ready = 1'b1;
          state_d  = bus.dmem_rsp_valid ? IDLE : DRAIN;
        end else if (bus.dmem_rsp_valid) begin
          in_ready   = 1'b1;
          wb_load    = 1'b1;
          wb_valid_d = 1'b1;
          ctrl_d     = bus.ctrl_mem[WB_CTRL_W-1:0];
          mem_data_d = rdata_ext;
          state_d    = IDLE;
        end
      end
      DRAIN: begin
        if (bus.dmem_rsp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wb_valid_q <= 1'b0;
      ctrl_q     <= '0;
      misal_q    <= 1'b0;
      mem_data_q <= '0;
      alu_q      <= '0;
      pc4_q      <= '0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
      ctrl_q     <= ctrl_d;
      misal_q    <= misal_d;
      if (wb_load) begin
        mem_data_q <= mem_data_d;
        alu_q      <= bus.alu_result;
        pc4_q      <= bus.pc4_mem;
        rd_q       <= bus.rd_mem;
      end
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.dmem_req_valid = req_valid;
  assign bus.dmem_we        = mem_wr;
  assign bus.dmem_be        = be;
  assign bus.dmem_addr      = {bus.alu_result[XLEN-1:OFF_W], {OFF_W{1'b0}}};
  assign bus.dmem_wdata     = wdata;
  assign bus.wb_valid       = wb_valid_q;
  assign bus.ctrl_wb        = ctrl_q;
  assign bus.rd_wb          = rd_q;
  assign bus.pc4_wb         = pc4_q;
  assign bus.mem_data       = mem_data_q;
  assign bus.alu_data       = alu_q;
  assign bus.misaligned     = misal_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Table-driven bench for mem_stage_hs with a write-back scoreboard and
// hand-written flush / reset sequences.
module tb_mem_stage_hs;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mem_stage_hs_if #(.XLEN(32), .WB_CTRL_W(3), .REG_ADDR_W(5)) bus ();

  mem_stage_hs #(.XLEN(32), .WB_CTRL_W(3), .REG_ADDR_W(5)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    logic [4:0]  ctrl;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rsp;
    int          req_wait;
    int          rsp_lat;
    logic        flush;
    logic        exp_req;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_mem;
    logic [2:0]  exp_ctrl;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic [2:0]  ctrl;
    logic        mis;
  } sb_t;

  sb_t  sb[$];
  vec_t vt[14];
  int   total = 0;
  int   bad   = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (bus.wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_wb", bus.wb_valid, 0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("wb_alu",  bus.alu_data,   e.alu);
        chk("wb_mem",  bus.mem_data,   e.mem);
        chk("wb_rd",   bus.rd_wb,      e.rd);
        chk("wb_pc4",  bus.pc4_wb,     e.pc4);
        chk("wb_ctrl", bus.ctrl_wb,    e.ctrl);
        chk("wb_mis",  bus.misaligned, e.mis);
      end
    end else begin
      chk("idle_ctrl", bus.ctrl_wb,    0);
      chk("idle_mis",  bus.misaligned, 0);
    end
  end

  task automatic push_exp(input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4,
                          input logic [4:0] rd, input logic [2:0] ctrl, input logic mis);
    sb_t e;
    e.alu = alu; e.mem = mem; e.pc4 = pc4; e.rd = rd; e.ctrl = ctrl; e.mis = mis;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [4:0] ctrl, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] pc4, input logic [31:0] addr, input logic [31:0] wd);
    bus.in_valid   = 1'b1;
    bus.ctrl_mem   = ctrl;
    bus.funct3     = f3;
    bus.rd_mem     = rd;
    bus.pc4_mem    = pc4;
    bus.alu_result = addr;
    bus.write_data = wd;
  endtask

  task automatic issue(input vec_t v);
    drive(v.ctrl, v.f3, v.rd, v.pc4, v.addr, v.wdata);
    bus.flush          = v.flush;
    bus.dmem_req_ready = (v.req_wait == 0);
    if (!v.flush) push_exp(v.addr, v.exp_mem, v.pc4, v.rd, v.exp_ctrl, v.exp_mis);
    @(negedge clk);
    chk("req_valid", bus.dmem_req_valid, v.exp_req);
    if (v.exp_req) begin
      for (int i = 0; i < v.req_wait; i++) begin
        chk("req_stall", bus.in_ready, 0);
        chk("stall_be",  bus.dmem_be,  v.exp_be);
        @(posedge clk); #1;
        if (i == v.req_wait - 1) bus.dmem_req_ready = 1'b1;
        @(negedge clk);
        chk("req_hold", bus.dmem_req_valid, 1);
      end
      chk("req_be",   bus.dmem_be,   v.exp_be);
      chk("req_addr", bus.dmem_addr, {v.addr[31:2], 2'b00});
      chk("req_we",   bus.dmem_we,   v.ctrl[4]);
      if (v.ctrl[4]) begin
        chk("req_wdata", bus.dmem_wdata, v.exp_wdata);
        chk("st_ready",  bus.in_ready,   1);
      end else begin
        chk("ld_ready", bus.in_ready, 0);
      end
      @(posedge clk); #1;
      bus.dmem_req_ready = 1'b0;
      if (!v.ctrl[4]) begin
        for (int i = 1; i < v.rsp_lat; i++) begin
          @(negedge clk);
          chk("rsp_wait", bus.in_ready, 0);
          chk("rsp_noreq", bus.dmem_req_valid, 0);
          @(posedge clk); #1;
        end
        bus.dmem_rsp_valid = 1'b1;
        bus.dmem_rsp_data  = v.rsp;
        @(negedge clk);
        chk("rsp_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.dmem_rsp_valid = 1'b0;
      end
    end else begin
      chk("nr_ready", bus.in_ready, 1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  // Accept a LW at 0x8000 and leave the stage in RSP
  task automatic start_load();
    drive(5'b01001, 3'b010, 5'd20, 32'h300, 32'h8000, 32'h0);
    bus.dmem_req_ready = 1'b1;
    @(negedge clk);
    chk("ld_req", bus.dmem_req_valid, 1);
    @(posedge clk); #1;
    bus.dmem_req_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            ctrl      f3      rd   pc4        addr        wdata         rsp         wt lat fl req be       exp_wdata     exp_mem       ctrl  mis
    vt[0]  = '{5'b00101, 3'b000, 5'd5,  32'h104, 32'h1234, 32'h0,        32'h0,        0, 0, 0, 0, 4'h0,    32'h0,        32'h0,        3'b101, 0};
    vt[1]  = '{5'b10000, 3'b000, 5'd0,  32'h108, 32'h1003, 32'hAABBCCDD, 32'h0,        2, 0, 0, 1, 4'b1000, 32'hDDDDDDDD, 32'h0,        3'b000, 0};
    vt[2]  = '{5'b01011, 3'b000, 5'd7,  32'h10C, 32'h2002, 32'h0,        32'h0080FF00, 0, 3, 0, 1, 4'b0100, 32'h0,        32'hFFFFFF80, 3'b011, 0};
    vt[3]  = '{5'b01011, 3'b100, 5'd8,  32'h110, 32'h2002, 32'h0,        32'h0080FF00, 0, 3, 0, 1, 4'b0100, 32'h0,        32'h00000080, 3'b011, 0};
    vt[4]  = '{5'b01111, 3'b001, 5'd9,  32'h114, 32'h3001, 32'h0,        32'h0,        0, 0, 0, 0, 4'h0,    32'h0,        32'h0,        3'b000, 1};
    vt[5]  = '{5'b10001, 3'b001, 5'd0,  32'h118, 32'h2002, 32'h1234BEEF, 32'h0,        1, 0, 0, 1, 4'b1100, 32'hBEEFBEEF, 32'h0,        3'b001, 0};
    vt[6]  = '{5'b10010, 3'b010, 5'd0,  32'h11C, 32'h4000, 32'hCAFEF00D, 32'h0,        0, 0, 0, 1, 4'hF,    32'hCAFEF00D, 32'h0,        3'b010, 0};
    vt[7]  = '{5'b01001, 3'b010, 5'd10, 32'h120, 32'h4004, 32'h0,        32'h87654321, 0, 1, 0, 1, 4'hF,    32'h0,        32'h87654321, 3'b001, 0};
    vt[8]  = '{5'b01001, 3'b101, 5'd11, 32'h124, 32'h5002, 32'h0,        32'h9ABC1234, 0, 2, 0, 1, 4'b1100, 32'h0,        32'h00009ABC, 3'b001, 0};
    vt[9]  = '{5'b01001, 3'b001, 5'd12, 32'h128, 32'h5000, 32'h0,        32'h12348001, 1, 1, 0, 1, 4'b0011, 32'h0,        32'hFFFF8001, 3'b001, 0};
    vt[10] = '{5'b10011, 3'b010, 5'd0,  32'h12C, 32'h6002, 32'h1,        32'h0,        0, 0, 0, 0, 4'h0,    32'h0,        32'h0,        3'b000, 1};
    vt[11] = '{5'b01001, 3'b111, 5'd13, 32'h130, 32'h7000, 32'h0,        32'hDEADBEEF, 0, 1, 0, 1, 4'hF,    32'h0,        32'hDEADBEEF, 3'b001, 0};
    vt[12] = '{5'b10000, 3'b011, 5'd0,  32'h134, 32'h7004, 32'h11223344, 32'h0,        0, 0, 0, 1, 4'hF,    32'h11223344, 32'h0,        3'b000, 0};
    vt[13] = '{5'b01001, 3'b010, 5'd14, 32'h138, 32'h8000, 32'h0,        32'h0,        0, 0, 1, 0, 4'h0,    32'h0,        32'h0,        3'b000, 0};

    reset_n            = 1'b0;
    bus.in_valid       = 1'b0;
    bus.ctrl_mem       = '0;
    bus.funct3         = '0;
    bus.rd_mem         = '0;
    bus.pc4_mem        = '0;
    bus.alu_result     = '0;
    bus.write_data     = '0;
    bus.flush          = 1'b0;
    bus.dmem_req_ready = 1'b0;
    bus.dmem_rsp_valid = 1'b0;
    bus.dmem_rsp_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_alu",      bus.alu_data, 0);
    chk("rst_mem",      bus.mem_data, 0);
    chk("rst_ready",    bus.in_ready, 1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 14; k++) begin
      issue(vt[k]);
      @(posedge clk); #1;
    end

    // Flush one cycle after LW acceptance; ADD waits out the drain
    start_load();
    bus.flush = 1'b1;
    @(negedge clk);
    chk("fl_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    drive(5'b00110, 3'b000, 5'd21, 32'h304, 32'h55, 32'h0);
    @(negedge clk);
    chk("drain_stall", bus.in_ready, 0);
    chk("drain_noreq", bus.dmem_req_valid, 0);
    @(posedge clk); #1;
    bus.dmem_rsp_valid = 1'b1;
    bus.dmem_rsp_data  = 32'hBAD0BAD0;
    @(negedge clk);
    chk("drain_rsp_stall", bus.in_ready, 0);
    @(posedge clk); #1;
    bus.dmem_rsp_valid = 1'b0;
    push_exp(32'h55, 32'h0, 32'h304, 5'd21, 3'b110, 1'b0);
    @(negedge clk);
    chk("post_drain_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;

    // Flush in the same cycle as the response: straight back to IDLE
    start_load();
    bus.flush          = 1'b1;
    bus.dmem_rsp_valid = 1'b1;
    bus.dmem_rsp_data  = 32'h0BADF00D;
    @(negedge clk);
    chk("flrsp_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.flush          = 1'b0;
    bus.dmem_rsp_valid = 1'b0;
    drive(5'b00011, 3'b000, 5'd22, 32'h308, 32'h66, 32'h0);
    push_exp(32'h66, 32'h0, 32'h308, 5'd22, 3'b011, 1'b0);
    @(negedge clk);
    chk("flrsp_idle", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset while a load is outstanding
    drive(5'b00111, 3'b000, 5'd3, 32'h200, 32'h99, 32'h0);
    push_exp(32'h99, 32'h0, 32'h200, 5'd3, 3'b111, 1'b0);
    @(posedge clk); #1;
    start_load();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", bus.wb_valid, 0);
    chk("arst_alu",   bus.alu_data, 0);
    chk("arst_rd",    bus.rd_wb,    0);
    chk("arst_pc4",   bus.pc4_wb,   0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("arst_ready", bus.in_ready, 1);
    chk("arst_noreq", bus.dmem_req_valid, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
